// File: rtl/datapath_n_pkg.sv
// Shared definitions for the datapath_n execution stage: opcode encoding
// and the legal width range.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_SLT = 3'b111
  } opcode_t;

  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 64;

endpackage

// File: rtl/datapath_n_if.sv
// Operand/opcode in, registered result/flag out for the datapath_n stage.
interface datapath_n_if #(
  parameter int N = 16
);
  logic signed [N-1:0] A;
  logic signed [N-1:0] B;
  logic        [2:0]   opcode;
  logic signed [N-1:0] Y;
  logic                co;

  modport master (output A, B, opcode, input Y, co);
  modport slave  (input A, B, opcode, output Y, co);
endinterface

// File: rtl/datapath_n_addsub.sv
// N-bit adder shared by ADD and SUB; SUB inverts b and injects carry-in so
// co reads 1 when no borrow occurs.
module datapath_addsub #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         co
);
  logic [N-1:0] b_eff;
  logic [N:0]   total;

  assign b_eff = sub ? ~b : b;
  assign total = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
  assign sum   = total[N-1:0];
  assign co    = total[N];
endmodule

// File: rtl/datapath_n.sv
// N-bit signed ALU execution stage: eight operations selected by opcode,
// result and carry/shift-out flag registered with one cycle of latency.
module datapath_n
  import datapath_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  datapath_n_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [N-1:0]        as_sum;
  logic                as_co;
  logic [SW-1:0]       s;
  logic [N:0]          sll_ext;
  logic signed [N:0]   sra_ext;
  logic                slt;
  logic signed [N-1:0] y_next;
  logic                co_next;

  datapath_addsub #(.N(N)) u_addsub (
    .a   (bus.A),
    .b   (bus.B),
    .sub (bus.opcode == OP_SUB),
    .sum (as_sum),
    .co  (as_co)
  );

  assign s = bus.B[SW-1:0];

  // One extra bit on the shifted-out side captures the last bit lost:
  // A[N-s] for SLL and A[s-1] for SRA, and a zero flag when s is 0.
  assign sll_ext = {1'b0, bus.A} << s;
  assign sra_ext = $signed({bus.A, 1'b0}) >>> s;
  assign slt     = (bus.A < bus.B);

  always_comb begin
    y_next  = '0;
    co_next = 1'b0;
    case (bus.opcode)
      OP_ADD,
      OP_SUB: begin
        y_next  = as_sum;
        co_next = as_co;
      end
      OP_AND: y_next = bus.A & bus.B;
      OP_OR:  y_next = bus.A | bus.B;
      OP_XOR: y_next = bus.A ^ bus.B;
      OP_SLL: {co_next, y_next} = sll_ext;
      OP_SRA: {y_next, co_next} = sra_ext;
      OP_SLT: y_next = {{(N-1){1'b0}}, slt};
      default: begin
        y_next  = '0;
        co_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Y  <= '0;
      bus.co <= 1'b0;
    end else begin
      bus.Y  <= y_next;
      bus.co <= co_next;
    end
  end
endmodule

// File: tb/tb_datapath_n.sv
// Scoreboard bench for datapath_n (N = 16): the driver queues expected
// {co, Y} per issued operation, the monitor pops one per clock edge.
module tb_datapath_n;
  logic clk = 1'b0;
  logic rst_n;

  datapath_n_if #(.N(16)) bus ();

  datapath_n #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [16:0] q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [16:0] exp;  // {co, Y}
  } vec_t;

  vec_t vecs[15] = '{
    '{16'h7FFF, 16'h0001, 3'b000, {1'b0, 16'h8000}},
    '{16'hFFFF, 16'h0001, 3'b000, {1'b1, 16'h0000}},
    '{16'h0005, 16'h0007, 3'b001, {1'b0, 16'hFFFE}},
    '{16'h0007, 16'h0005, 3'b001, {1'b1, 16'h0002}},
    '{16'hF0F0, 16'hFF00, 3'b010, {1'b0, 16'hF000}},
    '{16'hF0F0, 16'hFF00, 3'b011, {1'b0, 16'hFFF0}},
    '{16'hF0F0, 16'hFF00, 3'b100, {1'b0, 16'h0FF0}},
    '{16'h8001, 16'h0001, 3'b101, {1'b1, 16'h0002}},
    '{16'h8000, 16'h0014, 3'b110, {1'b0, 16'hF800}},
    '{16'hFFFD, 16'h0002, 3'b111, {1'b0, 16'h0001}},
    '{16'h8001, 16'h0010, 3'b101, {1'b0, 16'h8001}},
    '{16'h8001, 16'h000F, 3'b110, {1'b0, 16'hFFFF}},
    '{16'h4001, 16'h0001, 3'b110, {1'b1, 16'h2000}},
    '{16'h0002, 16'hFFFD, 3'b111, {1'b0, 16'h0000}},
    '{16'h00F0, 16'h0004, 3'b101, {1'b0, 16'h0F00}}
  };

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got co=%0b Y=%h, want co=%0b Y=%h at %0t",
               name, act[16], act[15:0], exp[16], exp[15:0], $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op);
    logic [16:0]        r;
    logic [31:0]        t;
    logic signed [15:0] sa;
    int                 sh;
    sh = int'(b[3:0]);
    sa = a;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: begin
        t = {16'h0, a} << sh;
        r = {(sh == 0) ? 1'b0 : t[16], t[15:0]};
      end
      3'd6: r = {(sh == 0) ? 1'b0 : a[sh-1], 16'(sa >>> sh)};
      default: r = {16'h0, ($signed(a) < $signed(b))};
    endcase
    return r;
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input logic [16:0] exp);
    bus.A      = a;
    bus.B      = b;
    bus.opcode = op;
    q.push_back(exp);
  endtask

  // Monitor: compare on each edge, then confirm the output holds while the
  // driver wiggles inputs mid-cycle.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result", {bus.co, bus.Y}, e);
        #3;
        check("hold", {bus.co, bus.Y}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [2:0]  rop;

    rst_n      = 1'b0;
    bus.A      = 16'd5;
    bus.B      = 16'd3;
    bus.opcode = 3'b000;
    #1;
    check("reset_async", {bus.co, bus.Y}, 17'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", {bus.co, bus.Y}, 17'h0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    q.push_back({1'b0, 16'd8});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      drive(ra, rb, rop, model(ra, rb, rop));
      @(posedge clk);
      #2;
      bus.A      = 16'($urandom);
      bus.B      = 16'($urandom);
      bus.opcode = 3'($urandom_range(0, 7));
    end

    // Reset lands between issue and capture: the queued result must never appear.
    @(negedge clk);
    drive(16'h1234, 16'h1111, 3'b000, {1'b0, 16'h2345});
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("reset_mid", {bus.co, bus.Y}, 17'h0);
    @(posedge clk);
    #1;
    check("reset_discard", {bus.co, bus.Y}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0003, 16'h0002, 3'b001, {1'b1, 16'h0001});

    begin
      int unsigned waited = 0;
      while (q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      @(negedge clk);
      if (q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending, want 0", q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/datapath_n.md
# datapath_n

Parameterised N-bit signed arithmetic/logic datapath: two signed operands and a 3-bit opcode select one of eight operations; result and carry flag are registered. Execution stage of the arithmetic pipeline, fed from operand registers/control decode and driving the result bus and flag logic.

## Interface
- N, default 16: operand/result width in bits; legal range 2..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  N  signed operand A.
- B  input  N  signed operand B; shift amount for shift operations.
- opcode  input  3  operation select.
- Y  output  N  signed registered result.
- co  output  1  registered carry/shift-out flag.

## Operation
- Opcodes:
  - 000 ADD: Y = A + B; co = carry out of bit N-1, unsigned sum.
  - 001 SUB: Y = A - B, computed as A + ~B + 1; co = carry out, 1 = no borrow.
  - 010 AND: Y = A & B; co = 0.
  - 011 OR: Y = A | B; co = 0.
  - 100 XOR: Y = A ^ B; co = 0.
  - 101 SLL: Y = A << s; co = last bit shifted out, A[N-s]; 0 when s = 0.
  - 110 SRA: Y = A >>> s, sign-filled; co = A[s-1]; 0 when s = 0.
  - 111 SLT: Y = 1 if A < B signed, else 0; co = 0.
- Shift amount s = B[$clog2(N)-1:0]; upper bits of B ignored.
- Signed overflow on ADD/SUB wraps modulo 2^N; no overflow flag.
- All opcodes decoded; no illegal-opcode case.

## Timing
- Next-state logic combinational from A, B, opcode; Y and co registered on rising clk.
- Latency exactly 1 cycle; new operation accepted every cycle; no handshake.
- rst_n low: Y = 0, co = 0 immediately, held until first rising clk after deassertion.
- Reset mid-operation: in-flight result discarded, never presented.
- Input changes between edges have no effect on outputs until the next edge.

## Structure
- Shared package datapath_pkg: opcode localparams/enum (OP_ADD..OP_SLT, 3 bits).
- One sub-module: datapath_addsub, N-bit adder with invert-B/carry-in control, returns sum and carry out; used by ADD and SUB. SLT derived by direct signed comparison.
- Logic, shifter and output mux inline in top level.

## Test plan
- Reset: rst_n = 0 with A = 5, B = 3, ADD, clk running -> Y = 0, co = 0; after release, next edge -> Y = 8, co = 0.
- ADD, N = 16: A = 16'h7FFF, B = 1 -> Y = 16'h8000, co = 0; A = -1, B = 1 -> Y = 0, co = 1.
- SUB: A = 5, B = 7 -> Y = 16'hFFFE (-2), co = 0; A = 7, B = 5 -> Y = 2, co = 1.
- Logic: A = 16'hF0F0, B = 16'hFF00 -> AND 16'hF000, OR 16'hFFF0, XOR 16'h0FF0, co = 0 each.
- Shifts/compare: SLL A = 16'h8001, B = 1 -> Y = 16'h0002, co = 1; SRA A = 16'h8000, B = 16'h0014 (s = 4) -> Y = 16'hF800, co = 0; SLT A = -3, B = 2 -> Y = 1, co = 0.
- Latency/random: back-to-back random A, B, opcode each cycle -> every output matches the reference model for the previous cycle's inputs; inputs toggled mid-cycle do not change Y.
